// File: rtl/tm_player_pkg.sv
// tm_player_pkg: shared definitions for the TM netlist vector player.
//   - state_e        : replay controller states
//   - VEC_W_DEF      : default vector width (one bit per netlist input)
//   - DEPTH_DEF      : default vector table depth
//   - LFSR_TAPS      : Galois tap mask for x^62+x^61+x^6+x^5+1 (right-shifting form)
//   - LFSR_SEED      : nonzero fallback seed used when table entry 0 is zero
package tm_player_pkg;

  localparam int unsigned VEC_W_DEF = 62;
  localparam int unsigned DEPTH_DEF = 10;

  localparam logic [61:0] LFSR_TAPS = 62'h3000_0000_0000_0030;
  localparam logic [61:0] LFSR_SEED = 62'h2AAA_AAAA_5555_5555;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    FIN
  } state_e;

endpackage

// File: rtl/tm_player_lfsr.sv
// tm_player_lfsr: W-bit right-shifting Galois LFSR with synchronous seed load.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset (state cleared)
//   load_i  : load seed_i into the state (priority over en_i)
//   seed_i  : seed value
//   en_i    : advance the LFSR one step
//   next_o  : value the state takes on the next advance
module tm_player_lfsr
  import tm_player_pkg::*;
#(
  parameter int unsigned    W    = VEC_W_DEF,
  parameter logic [W-1:0]   TAPS = W'(LFSR_TAPS)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] seed_i,
  input  logic         en_i,
  output logic [W-1:0] next_o
);

  logic [W-1:0] state_q;

  assign next_o = state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= '0;
    end else if (load_i) begin
      state_q <= seed_i;
    end else if (en_i) begin
      state_q <= next_o;
    end
  end

endmodule

// File: rtl/tm_vector_player.sv
// tm_vector_player: loads a small table of input vectors and replays them,
// one per clock, for a programmable number of passes. vec_out is registered
// and holds its last value outside of replay.
// Optional: define TM_PLAYER_LFSR_EN to add lfsr_mode, which replaces table
// data with a Galois LFSR sequence seeded from table entry 0.
// Ports:
//   clk, rst (async active-low)
//   clear                       : empty the table (IDLE only, beats a load)
//   load_valid/load_ready/load_data : append one vector to the table
//   start/abort/stall/loops     : replay control; loops==0 means one pass
//   vec_out/vec_valid/vec_idx   : registered vector, fresh flag, table index
//   count                       : entries loaded
//   busy                        : replay in progress
//   done                        : one-cycle completion/abort pulse
module tm_vector_player
  import tm_player_pkg::*;
#(
  parameter int unsigned VEC_W  = VEC_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned LOOP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [VEC_W-1:0]  load_data,
  input  logic              start,
  input  logic              abort,
  input  logic              stall,
  input  logic [LOOP_W-1:0] loops,
`ifdef TM_PLAYER_LFSR_EN
  input  logic              lfsr_mode,
`endif
  output logic [VEC_W-1:0]  vec_out,
  output logic              vec_valid,
  output logic [ADDR_W-1:0] vec_idx,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done
);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [VEC_W-1:0]    mem_q [DEPTH];
  logic [LOOP_W-1:0]   passes_q, passes_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic                last_q, last_d;
  logic [VEC_W-1:0]    vec_out_q, vec_out_d;
  logic                vec_valid_q, vec_valid_d;
  logic [ADDR_W-1:0]   vec_idx_q, vec_idx_d;

  logic                wr_en;
  logic                entry;
  logic                present;
  logic [ADDR_W-1:0]   cur_rd;
  logic [LOOP_W-1:0]   cur_passes;
  logic [VEC_W-1:0]    play_data;

  assign load_ready = (state_q == IDLE) && (count_q < (ADDR_W+1)'(DEPTH));

`ifdef TM_PLAYER_LFSR_EN
  logic             mode_q, mode_d;
  logic             use_lfsr;
  logic [VEC_W-1:0] lfsr_seed;
  logic [VEC_W-1:0] lfsr_next;

  assign lfsr_seed = (mem_q[0] == '0) ? VEC_W'(LFSR_SEED) : mem_q[0];
  assign use_lfsr  = entry ? lfsr_mode : mode_q;
  assign play_data = use_lfsr ? (entry ? lfsr_seed : lfsr_next) : mem_q[cur_rd];

  tm_player_lfsr #(
    .W    (VEC_W),
    .TAPS (VEC_W'(LFSR_TAPS))
  ) u_lfsr (
    .clk_i  (clk),
    .rst_ni (rst),
    .load_i (entry),
    .seed_i (lfsr_seed),
    .en_i   (present && !entry),
    .next_o (lfsr_next)
  );

  always_comb begin
    mode_d = mode_q;
    if (entry) mode_d = lfsr_mode;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mode_q <= 1'b0;
    else      mode_q <= mode_d;
  end
`else
  assign play_data = mem_q[cur_rd];
`endif

  // The output registers are loaded one step ahead of the replay state, so the
  // first vector appears in the cycle after start and every PLAY cycle carries
  // a vector; last_q marks that the vector now showing is the final one.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    passes_d    = passes_q;
    rd_ptr_d    = rd_ptr_q;
    last_d      = last_q;
    vec_out_d   = vec_out_q;
    vec_valid_d = vec_valid_q;
    vec_idx_d   = vec_idx_q;
    wr_en       = 1'b0;
    entry       = 1'b0;
    present     = 1'b0;
    cur_rd      = rd_ptr_q;
    cur_passes  = passes_q;

    unique case (state_q)
      IDLE: begin
        if (clear) begin
          count_d = '0;
        end else begin
          if (load_valid && load_ready) begin
            wr_en   = 1'b1;
            count_d = count_q + (ADDR_W+1)'(1);
          end
          if (start && (count_q != '0)) begin
            state_d    = PLAY;
            entry      = 1'b1;
            present    = 1'b1;
            cur_rd     = '0;
            cur_passes = (loops == '0) ? LOOP_W'(1) : loops;
          end
        end
      end
      PLAY: begin
        if (abort || (!stall && last_q)) begin
          state_d     = FIN;
          vec_valid_d = 1'b0;
        end else if (stall) begin
          vec_valid_d = 1'b0;
        end else begin
          present = 1'b1;
        end
      end
      FIN: begin
        state_d     = IDLE;
        vec_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // count_d covers a load accepted in the same cycle as start.
    if (present) begin
      vec_out_d   = play_data;
      vec_idx_d   = cur_rd;
      vec_valid_d = 1'b1;
      if ({1'b0, cur_rd} == (count_d - (ADDR_W+1)'(1))) begin
        rd_ptr_d = '0;
        passes_d = cur_passes - LOOP_W'(1);
        last_d   = (cur_passes == LOOP_W'(1));
      end else begin
        rd_ptr_d = cur_rd + ADDR_W'(1);
        passes_d = cur_passes;
        last_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      passes_q    <= '0;
      rd_ptr_q    <= '0;
      last_q      <= 1'b0;
      vec_out_q   <= '0;
      vec_valid_q <= 1'b0;
      vec_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      passes_q    <= passes_d;
      rd_ptr_q    <= rd_ptr_d;
      last_q      <= last_d;
      vec_out_q   <= vec_out_d;
      vec_valid_q <= vec_valid_d;
      vec_idx_q   <= vec_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[count_q[ADDR_W-1:0]] <= load_data;
  end

  assign vec_out   = vec_out_q;
  assign vec_valid = vec_valid_q;
  assign vec_idx   = vec_idx_q;
  assign count     = count_q;
  assign busy      = (state_q == PLAY);
  assign done      = (state_q == FIN);

endmodule

// File: tb/tb_tm_vector_player.sv
module tb_tm_vector_player;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        load_valid;
  logic        load_ready;
  logic [61:0] load_data;
  logic        start;
  logic        abort;
  logic        stall;
  logic [15:0] loops;
  logic [61:0] vec_out;
  logic        vec_valid;
  logic [3:0]  vec_idx;
  logic [4:0]  count;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tm_vector_player #(
    .VEC_W  (62),
    .DEPTH  (10),
    .ADDR_W (4),
    .LOOP_W (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .start      (start),
    .abort      (abort),
    .stall      (stall),
    .loops      (loops),
    .vec_out    (vec_out),
    .vec_valid  (vec_valid),
    .vec_idx    (vec_idx),
    .count      (count),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [61:0] d;
    logic [4:0]  cnt;
    logic        rdy;
  } ld_t;

  typedef struct {
    logic        st;
    logic        sl;
    logic [61:0] out;
    logic [3:0]  idx;
    logic        vld;
    logic        bsy;
    logic        dn;
  } step_t;

  ld_t   ld_tab [11];
  step_t wrap_tab [$];
  step_t stall_tab [$];

  function automatic step_t mk(logic st, logic sl, logic [61:0] out, logic [3:0] idx,
                               logic vld, logic bsy, logic dn);
    step_t s;
    s.st = st; s.sl = sl; s.out = out; s.idx = idx;
    s.vld = vld; s.bsy = bsy; s.dn = dn;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic load_vec(input logic [61:0] d);
    load_valid = 1'b1;
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic run_steps(input string tag, input step_t tab [$]);
    foreach (tab[i]) begin
      chk($sformatf("%s[%0d].vec_out", tag, i), 64'(vec_out), 64'(tab[i].out));
      chk($sformatf("%s[%0d].vec_idx", tag, i), 64'(vec_idx), 64'(tab[i].idx));
      chk($sformatf("%s[%0d].vec_valid", tag, i), 64'(vec_valid), 64'(tab[i].vld));
      chk($sformatf("%s[%0d].busy", tag, i), 64'(busy), 64'(tab[i].bsy));
      chk($sformatf("%s[%0d].done", tag, i), 64'(done), 64'(tab[i].dn));
      start = tab[i].st;
      stall = tab[i].sl;
      tick();
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    // load table: ten vectors 1..10, then an 11th that must be dropped
    for (int i = 0; i < 10; i++) begin
      ld_tab[i].d   = 62'(i + 1);
      ld_tab[i].cnt = 5'(i + 1);
      ld_tab[i].rdy = (i < 9);
    end
    ld_tab[10].d   = 62'hFF;
    ld_tab[10].cnt = 5'd10;
    ld_tab[10].rdy = 1'b0;

    // count=3 table {11,22,33}, loops=2, start held high during play (ignored)
    wrap_tab.push_back(mk(1, 0, 62'hA,  4'd9, 0, 0, 0));
    wrap_tab.push_back(mk(1, 0, 62'h11, 4'd0, 1, 1, 0));
    wrap_tab.push_back(mk(1, 0, 62'h22, 4'd1, 1, 1, 0));
    wrap_tab.push_back(mk(1, 0, 62'h33, 4'd2, 1, 1, 0));
    wrap_tab.push_back(mk(0, 0, 62'h11, 4'd0, 1, 1, 0));
    wrap_tab.push_back(mk(0, 0, 62'h22, 4'd1, 1, 1, 0));
    wrap_tab.push_back(mk(0, 0, 62'h33, 4'd2, 1, 1, 0));
    wrap_tab.push_back(mk(0, 0, 62'h33, 4'd2, 0, 0, 1));
    wrap_tab.push_back(mk(0, 0, 62'h33, 4'd2, 0, 0, 0));

    // same table, stall for two cycles while the 2nd vector shows
    stall_tab.push_back(mk(1, 0, 62'h33, 4'd2, 0, 0, 0));
    stall_tab.push_back(mk(0, 0, 62'h11, 4'd0, 1, 1, 0));
    stall_tab.push_back(mk(0, 1, 62'h22, 4'd1, 1, 1, 0));
    stall_tab.push_back(mk(0, 1, 62'h22, 4'd1, 0, 1, 0));
    stall_tab.push_back(mk(0, 0, 62'h22, 4'd1, 0, 1, 0));
    stall_tab.push_back(mk(0, 0, 62'h33, 4'd2, 1, 1, 0));
    stall_tab.push_back(mk(0, 0, 62'h11, 4'd0, 1, 1, 0));
    stall_tab.push_back(mk(0, 0, 62'h22, 4'd1, 1, 1, 0));
    stall_tab.push_back(mk(0, 0, 62'h33, 4'd2, 1, 1, 0));
    stall_tab.push_back(mk(0, 0, 62'h33, 4'd2, 0, 0, 1));
    stall_tab.push_back(mk(0, 0, 62'h33, 4'd2, 0, 0, 0));

    rst = 1'b0; clear = 1'b0; load_valid = 1'b0; load_data = '0;
    start = 1'b0; abort = 1'b0; stall = 1'b0; loops = '0;
    tick(); tick();

    // reset state
    chk("rst.vec_out", 64'(vec_out), 64'h0);
    chk("rst.vec_valid", 64'(vec_valid), 64'h0);
    chk("rst.vec_idx", 64'(vec_idx), 64'h0);
    chk("rst.count", 64'(count), 64'h0);
    chk("rst.busy", 64'(busy), 64'h0);
    chk("rst.done", 64'(done), 64'h0);
    rst = 1'b1;
    tick();
    chk("idle.load_ready", 64'(load_ready), 64'h1);

    // table fill and overflow drop
    for (int i = 0; i < 11; i++) begin
      load_vec(ld_tab[i].d);
      chk($sformatf("load[%0d].count", i), 64'(count), 64'(ld_tab[i].cnt));
      chk($sformatf("load[%0d].load_ready", i), 64'(load_ready), 64'(ld_tab[i].rdy));
    end

    // single pass, loops=0
    loops = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("single[%0d].vec_out", k), 64'(vec_out), 64'(k + 1));
      chk($sformatf("single[%0d].vec_idx", k), 64'(vec_idx), 64'(k));
      chk($sformatf("single[%0d].vec_valid", k), 64'(vec_valid), 64'h1);
      chk($sformatf("single[%0d].done", k), 64'(done), 64'h0);
      tick();
    end
    chk("single.fin.done", 64'(done), 64'h1);
    chk("single.fin.vec_valid", 64'(vec_valid), 64'h0);
    chk("single.fin.vec_out", 64'(vec_out), 64'hA);
    chk("single.fin.busy", 64'(busy), 64'h0);
    tick();
    chk("single.idle.done", 64'(done), 64'h0);
    chk("single.idle.vec_out", 64'(vec_out), 64'hA);

    // clear beats a same-cycle load
    clear = 1'b1;
    load_valid = 1'b1;
    load_data = 62'h77;
    tick();
    clear = 1'b0;
    load_valid = 1'b0;
    chk("clear.count", 64'(count), 64'h0);

    load_vec(62'h11);
    load_vec(62'h22);
    load_vec(62'h33);
    chk("wrap.count", 64'(count), 64'h3);
    loops = 16'd2;
    run_steps("wrap", wrap_tab);
    run_steps("stall", stall_tab);

    // abort at vector 5, same cycle as a stall
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 10; i++) load_vec(62'(i + 1));
    loops = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("abort.pre.vec_out", 64'(vec_out), 64'h5);
    abort = 1'b1;
    stall = 1'b1;
    tick();
    abort = 1'b0;
    stall = 1'b0;
    chk("abort.done", 64'(done), 64'h1);
    chk("abort.vec_out", 64'(vec_out), 64'h5);
    chk("abort.busy", 64'(busy), 64'h0);
    chk("abort.vec_valid", 64'(vec_valid), 64'h0);
    tick();
    chk("abort.idle.done", 64'(done), 64'h0);

    // start with an empty table
    clear = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("empty.busy", 64'(busy), 64'h0);
    chk("empty.done", 64'(done), 64'h0);
    tick();
    chk("empty.done2", 64'(done), 64'h0);
    chk("empty.vec_out", 64'(vec_out), 64'h5);

    // asynchronous reset during play
    for (int i = 0; i < 10; i++) load_vec(62'(i + 1));
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("areset.pre.vec_out", 64'(vec_out), 64'h4);
    #2;
    rst = 1'b0;
    #1;
    chk("areset.vec_out", 64'(vec_out), 64'h0);
    chk("areset.busy", 64'(busy), 64'h0);
    chk("areset.count", 64'(count), 64'h0);
    chk("areset.done", 64'(done), 64'h0);
    chk("areset.vec_valid", 64'(vec_valid), 64'h0);
    tick();
    rst = 1'b1;
    tick();
    chk("areset.after.done", 64'(done), 64'h0);
    chk("areset.after.busy", 64'(busy), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
